frame_sequencer: RTL and testbench

//  Sequences one full display refresh through the image controller: steps byte_counter 0..FRAME_BYTES-1,

---
 rtl/frame_sequencer_if.sv | 47 ++++
 rtl/frame_sequencer.sv | 208 ++++++++++++++++++++
 tb/tb_frame_sequencer.sv | 287 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_sequencer_if.sv
// rtl/frame_sequencer_if.sv - image-controller and SPI-transmitter bus of the frame sequencer
//
// Purpose
//    Bundles the signals the frame sequencer shares with its neighbours:
//    the image-controller read port (estado, byte_counter, data_in) and the
//    valid/ready byte stream toward the SPI display transmitter.
//
// Signals
//    estado        4      frame-latched game state, sequencer -> image controller
//    byte_counter  CNT_W  byte index, sequencer -> image controller
//    data_in       8      registered image byte, image controller -> sequencer
//    spi_data      8      byte offered to the SPI transmitter
//    spi_valid     1      spi_data is valid
//    spi_ready     1      transmitter accepts on a clk edge with spi_valid high
//
// Modports
//    master  the frame sequencer
//    slave   the image controller / SPI transmitter side

interface frame_sequencer_if #(
   parameter int CNT_W = 10
);
   logic [3:0]       estado;
   logic [CNT_W-1:0] byte_counter;
   logic [7:0]       data_in;
   logic [7:0]       spi_data;
   logic             spi_valid;
   logic             spi_ready;

   modport master (
      output estado,
      output byte_counter,
      output spi_data,
      output spi_valid,
      input  data_in,
      input  spi_ready
   );

   modport slave (
      input  estado,
      input  byte_counter,
      input  spi_data,
      input  spi_valid,
      output data_in,
      output spi_ready
   );
endinterface

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - sequences one display refresh from the image controller to the SPI transmitter
//
// Purpose
//    Walks byte_counter 0..FRAME_BYTES-1, waits out the image controller's
//    one-cycle registered read, and hands each byte to the SPI transmitter
//    over a valid/ready handshake. The game state is latched once per frame
//    so a single frame never mixes two images. Between frames the block
//    idles FRAME_GAP clocks before sampling enable again.
//
// Parameters
//    FRAME_BYTES  bytes per frame
//    CNT_W        width of byte_counter, 2**CNT_W >= FRAME_BYTES
//    FRAME_GAP    idle clocks after frame_done before the next start (>= 1)
//
// Ports
//    i_clk          system clock
//    i_rst_n        asynchronous reset, active low
//    i_enable       refresh continuously while high, sampled only when idle
//    i_estado_in    game state from the game FSM (one-hot or 0)
//    io_bus         image-controller read port and SPI byte stream (master)
//    o_frame_start  1-clk pulse on the first byte address of a frame
//    o_frame_done   1-clk pulse after the last byte is accepted
//    o_busy         high in every state except idle
//    o_frame_sum    16-bit running sum of accepted bytes (FRAME_CHECKSUM_EN only)
//
// Configuration
//    FRAME_CHECKSUM_EN  when defined, adds o_frame_sum: cleared at frame
//                       start, final from the frame_done cycle until the
//                       next frame start.

module frame_sequencer #(
   parameter int FRAME_BYTES = 1024,
   parameter int CNT_W       = 10,
   parameter int FRAME_GAP   = 16
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_enable,
   input  logic [3:0]               i_estado_in,
   frame_sequencer_if.master        io_bus,
   output logic                     o_frame_start,
   output logic                     o_frame_done,
`ifdef FRAME_CHECKSUM_EN
   output logic [15:0]              o_frame_sum,
`endif
   output logic                     o_busy
);

   // Gap counter only needs to hold FRAME_GAP-1; keep at least one bit.
   localparam int               GAP_W    = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(FRAME_GAP - 1);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_BYTES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WAIT,
      S_SEND,
      S_GAP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [CNT_W-1:0] r_byte_cnt;
   logic [CNT_W-1:0] w_byte_cnt_nxt;
   logic [3:0]       r_estado;
   logic [3:0]       w_estado_nxt;
   logic [7:0]       r_spi_data;
   logic [7:0]       w_spi_data_nxt;
   logic             r_spi_valid;
   logic             w_spi_valid_nxt;
   logic             r_frame_start;
   logic             w_frame_start_nxt;
   logic             r_frame_done;
   logic             w_frame_done_nxt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_cnt_nxt;

   logic             w_accept;
   logic             w_estado_ok;

`ifdef FRAME_CHECKSUM_EN
   logic [15:0]      r_frame_sum;
   logic [15:0]      w_frame_sum_nxt;
`endif

   // A byte leaves only from S_SEND; ready seen in any other state is ignored.
   assign w_accept = (r_state == S_SEND) && r_spi_valid && io_bus.spi_ready;

   // Zero or exactly one bit set: x & (x-1) clears the lowest set bit.
   assign w_estado_ok = ((i_estado_in & (i_estado_in - 4'd1)) == 4'd0);

   always_comb begin
      w_state_nxt       = r_state;
      w_byte_cnt_nxt    = r_byte_cnt;
      w_estado_nxt      = r_estado;
      w_spi_data_nxt    = r_spi_data;
      w_spi_valid_nxt   = r_spi_valid;
      w_frame_start_nxt = 1'b0;
      w_frame_done_nxt  = 1'b0;
      w_gap_cnt_nxt     = r_gap_cnt;
`ifdef FRAME_CHECKSUM_EN
      w_frame_sum_nxt   = r_frame_sum;
`endif

      case (r_state)
         S_IDLE: begin
            if (i_enable) begin
               w_state_nxt       = S_ADDR;
               w_byte_cnt_nxt    = '0;
               w_frame_start_nxt = 1'b1;
               // Malformed game states keep the previous image for this frame.
               if (w_estado_ok) begin
                  w_estado_nxt = i_estado_in;
               end
`ifdef FRAME_CHECKSUM_EN
               w_frame_sum_nxt   = 16'h0000;
`endif
            end
         end

         S_ADDR: begin
            // Address is presented this cycle; the controller registers the byte.
            w_state_nxt = S_WAIT;
         end

         S_WAIT: begin
            w_spi_data_nxt  = io_bus.data_in;
            w_spi_valid_nxt = 1'b1;
            w_state_nxt     = S_SEND;
         end

         S_SEND: begin
            if (w_accept) begin
               w_spi_valid_nxt = 1'b0;
`ifdef FRAME_CHECKSUM_EN
               w_frame_sum_nxt = r_frame_sum + {8'h00, r_spi_data};
`endif
               if (r_byte_cnt == LAST_IDX) begin
                  // Counter parks on the last index; no wrap inside a frame.
                  w_state_nxt      = S_GAP;
                  w_frame_done_nxt = 1'b1;
                  w_gap_cnt_nxt    = GAP_INIT;
               end else begin
                  w_byte_cnt_nxt = r_byte_cnt + CNT_W'(1);
                  w_state_nxt    = S_ADDR;
               end
            end
         end

         S_GAP: begin
            if (r_gap_cnt == '0) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_gap_cnt_nxt = r_gap_cnt - GAP_W'(1);
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= S_IDLE;
         r_byte_cnt    <= '0;
         r_estado      <= 4'h0;
         r_spi_data    <= 8'h00;
         r_spi_valid   <= 1'b0;
         r_frame_start <= 1'b0;
         r_frame_done  <= 1'b0;
         r_gap_cnt     <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_byte_cnt    <= w_byte_cnt_nxt;
         r_estado      <= w_estado_nxt;
         r_spi_data    <= w_spi_data_nxt;
         r_spi_valid   <= w_spi_valid_nxt;
         r_frame_start <= w_frame_start_nxt;
         r_frame_done  <= w_frame_done_nxt;
         r_gap_cnt     <= w_gap_cnt_nxt;
      end
   end

`ifdef FRAME_CHECKSUM_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_frame_sum <= 16'h0000;
      end else begin
         r_frame_sum <= w_frame_sum_nxt;
      end
   end

   assign o_frame_sum = r_frame_sum;
`endif

   assign io_bus.estado       = r_estado;
   assign io_bus.byte_counter = r_byte_cnt;
   assign io_bus.spi_data     = r_spi_data;
   assign io_bus.spi_valid    = r_spi_valid;
   assign o_frame_start       = r_frame_start;
   assign o_frame_done        = r_frame_done;
   assign o_busy              = (r_state != S_IDLE);

endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - self-checking bench for frame_sequencer with a behavioural frame model

module tb_frame_sequencer;

   localparam int FB = 8;
   localparam int CW = 3;
   localparam int FG = 4;
   localparam int LOG_N = 4096;

   logic       clk;
   logic       rst_n;
   logic       enable;
   logic [3:0] estado_in;
   logic       frame_start;
   logic       frame_done;
   logic       busy;
`ifdef FRAME_CHECKSUM_EN
   logic [15:0] frame_sum;
`endif

   frame_sequencer_if #(.CNT_W(CW)) io ();

   frame_sequencer #(
      .FRAME_BYTES (FB),
      .CNT_W       (CW),
      .FRAME_GAP   (FG)
   ) dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .i_enable      (enable),
      .i_estado_in   (estado_in),
      .io_bus        (io.master),
      .o_frame_start (frame_start),
      .o_frame_done  (frame_done),
`ifdef FRAME_CHECKSUM_EN
      .o_frame_sum   (frame_sum),
`endif
      .o_busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int stall_left = 0;
   bit ready_rand = 1'b0;
   int mon_err = 0;

   logic [7:0] img [0:8][0:7];
   logic       ready_log [0:LOG_N-1];

   int         start_q[$];
   int         done_q[$];
   int         acc_edge_q[$];
   logic [7:0] acc_data_q[$];
   logic [3:0] est_q[$];
   logic [15:0] sum_q[$];

   logic       p_hold = 1'b0;
   logic [7:0] p_data;
   logic [CW-1:0] p_cnt;

   always @(posedge clk) cyc <= cyc + 1;

   // Image controller: registered read of the latched image.
   always @(posedge clk) io.data_in <= img[int'(io.estado)][int'(io.byte_counter)];

   // Passive monitor: event log and handshake hold invariants.
   always @(negedge clk) begin
      if (!rst_n) begin
         p_hold = 1'b0;
      end else begin
         if (frame_start && frame_done) mon_err++;
         if (p_hold) begin
            if (io.spi_valid !== 1'b1 || io.spi_data !== p_data || io.byte_counter !== p_cnt) mon_err++;
         end
         p_hold = io.spi_valid && !io.spi_ready;
         p_data = io.spi_data;
         p_cnt  = io.byte_counter;
         if (io.spi_valid && io.spi_ready) begin
            acc_edge_q.push_back(cyc + 1);
            acc_data_q.push_back(io.spi_data);
         end
         if (frame_start) begin
            start_q.push_back(cyc);
            est_q.push_back(io.estado);
         end
         if (frame_done) begin
            done_q.push_back(cyc);
`ifdef FRAME_CHECKSUM_EN
            sum_q.push_back(frame_sum);
`endif
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      if (stall_left > 0) begin
         io.spi_ready = 1'b0;
         stall_left--;
      end else if (ready_rand) begin
         io.spi_ready = ($urandom_range(0, 3) != 0);
      end else begin
         io.spi_ready = 1'b1;
      end
      if (cyc < LOG_N) ready_log[cyc] = io.spi_ready;
   endtask

   task automatic wait_for(input string tag, input int nstarts, input int b, input bit need_valid);
      int n;
      n = 0;
      while (n < 2000 && !(start_q.size() >= nstarts && int'(io.byte_counter) == b &&
                           (!need_valid || io.spi_valid))) begin
         tick();
         n++;
      end
      chk(tag, 32'(n < 2000), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_estado"}, 32'(io.estado), 32'd0);
      chk({tag, "_byte_counter"}, 32'(io.byte_counter), 32'd0);
      chk({tag, "_spi_data"}, 32'(io.spi_data), 32'd0);
      chk({tag, "_spi_valid"}, 32'(io.spi_valid), 32'd0);
      chk({tag, "_frame_start"}, 32'(frame_start), 32'd0);
      chk({tag, "_frame_done"}, 32'(frame_done), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
`ifdef FRAME_CHECKSUM_EN
      chk({tag, "_frame_sum"}, 32'(frame_sum), 32'd0);
`endif
   endtask

   // Reference frame model: byte n leaves at the first edge at least three
   // clocks after the previous acceptance (or the frame start) at which ready
   // was high during the preceding cycle; bytes are the latched image in order.
   task automatic check_frame(input string tag, input int s, input int e, output int d);
      int t;
      int sum;
      t = s;
      sum = 0;
      for (int n = 0; n < FB; n++) begin
         t += 3;
         while (t < LOG_N && ready_log[t-1] !== 1'b1) t++;
         if (acc_edge_q.size() == 0) begin
            chk({tag, "_accept_count"}, 32'(n), 32'(FB));
            break;
         end
         chk({tag, "_accept_edge"}, 32'(acc_edge_q.pop_front()), 32'(t));
         chk({tag, "_accept_data"}, 32'(acc_data_q.pop_front()), 32'(img[e][n]));
         sum += int'(img[e][n]);
      end
      d = t;
      if (done_q.size() == 0) begin
         chk({tag, "_done_present"}, 32'd0, 32'd1);
      end else begin
         chk({tag, "_done_edge"}, 32'(done_q.pop_front()), 32'(t));
`ifdef FRAME_CHECKSUM_EN
         chk({tag, "_frame_sum"}, 32'(sum_q.pop_front()), 32'(sum & 16'hFFFF));
`endif
      end
   endtask

   initial begin
      int d_edge [0:4];
      int exp_est [0:4];
      int idle_edge;
      int n;
      int d7;

      exp_est[0] = 1; exp_est[1] = 1; exp_est[2] = 2; exp_est[3] = 2; exp_est[4] = 8;
      for (int e = 0; e < 9; e++)
         for (int b = 0; b < FB; b++)
            img[e][b] = 8'($urandom);
      for (int b = 0; b < FB; b++) img[1][b] = 8'hA0 + 8'(b);
      img[8][0] = 8'hFF; img[8][1] = 8'hFF; img[8][2] = 8'h01;
      for (int b = 3; b < FB; b++) img[8][b] = 8'h00;

      rst_n = 1'b0;
      enable = 1'b0;
      estado_in = 4'h0;
      io.spi_ready = 1'b1;
      repeat (3) tick();
      chk_all_zero("reset");

      // Frames 1..5: clean frame, stall + mid-frame estado change, bad estado, enable drop.
      enable = 1'b1;
      estado_in = 4'h1;
      rst_n = 1'b1;

      wait_for("wait_f2_b3", 2, 3, 1'b1);
      io.spi_ready = 1'b0;
      ready_log[cyc] = 1'b0;
      stall_left = 4;
      for (int k = 0; k < 5; k++) begin
         chk("stall_valid", 32'(io.spi_valid), 32'd1);
         chk("stall_data", 32'(io.spi_data), 32'(img[1][3]));
         chk("stall_byte_counter", 32'(io.byte_counter), 32'd3);
         tick();
      end

      wait_for("wait_f2_b4", 2, 4, 1'b0);
      estado_in = 4'h2;
      wait_for("wait_f3_b1", 3, 1, 1'b0);
      ready_rand = 1'b1;
      estado_in = 4'b0011;
      wait_for("wait_f4_b1", 4, 1, 1'b0);
      estado_in = 4'h8;
      wait_for("wait_f5_b2", 5, 2, 1'b0);
      enable = 1'b0;

      n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk("wait_idle", 32'(n < 2000), 32'd1);
      idle_edge = cyc;
      repeat (40) tick();

      chk("phaseA_starts", 32'(start_q.size()), 32'd5);
      chk("phaseA_dones", 32'(done_q.size()), 32'd5);
      if (start_q.size() == 5 && done_q.size() == 5) begin
         chk("f1_frame_len", 32'(done_q[0] - start_q[0]), 32'(3 * FB));
         for (int i = 0; i < 5; i++) begin
            chk($sformatf("f%0d_estado", i + 1), 32'(est_q[i]), 32'(exp_est[i]));
            check_frame($sformatf("f%0d", i + 1), start_q[i], exp_est[i], d_edge[i]);
         end
         for (int i = 0; i < 4; i++)
            chk($sformatf("f%0d_start_gap", i + 2), 32'(start_q[i+1]), 32'(d_edge[i] + FG + 1));
         chk("busy_fall_edge", 32'(idle_edge), 32'(d_edge[4] + FG));
      end
      chk("monitor_invariants", 32'(mon_err), 32'd0);

      // Frame 6 abandoned by reset at byte 5, frame 7 restarts cleanly.
      start_q.delete(); done_q.delete(); acc_edge_q.delete();
      acc_data_q.delete(); est_q.delete(); sum_q.delete();
      estado_in = 4'h4;
      enable = 1'b1;
      wait_for("wait_f6_b5", 1, 5, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async_reset");
      repeat (3) tick();
      chk("reset_no_done", 32'(done_q.size()), 32'd0);
      start_q.delete(); done_q.delete(); acc_edge_q.delete();
      acc_data_q.delete(); est_q.delete(); sum_q.delete();
      rst_n = 1'b1;

      n = 0;
      while (done_q.size() == 0 && n < 2000) begin
         tick();
         n++;
      end
      chk("wait_f7_done", 32'(n < 2000), 32'd1);
      enable = 1'b0;
      if (start_q.size() >= 1 && done_q.size() >= 1) begin
         chk("f7_estado", 32'(est_q[0]), 32'd4);
         check_frame("f7", start_q[0], 4, d7);
         chk("f7_no_extra_bytes", 32'(acc_edge_q.size()), 32'd0);
      end

      n = 0;
      while (busy && n < 2000) begin
         tick();
         n++;
      end
      chk("final_idle", 32'(n < 2000), 32'd1);
      chk("monitor_invariants_end", 32'(mon_err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
